// File: rtl/reg_fifo.sv
// reg_fifo: synchronous show-ahead FIFO on a register-file array.
// Buffers D_BIT-wide words between the UART datapath and the host side.
// Ports:
//   clk, rst (async, active-high), clr (sync flush, also clears ovf/udf)
//   wr/w_data  push request and data
//   rd         pop request; r_data always shows the head word (0 when empty)
//   empty/full/almost_empty/almost_full  flags decoded from count
//   count      occupancy 0..2**W
//   ovf/udf    sticky overflow/underflow flags
module reg_fifo #(
  parameter int unsigned D_BIT  = 8,
  parameter int unsigned W      = 4,
  parameter int unsigned AF_LVL = 2**W - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [D_BIT-1:0] w_data,
  input  logic             rd,
  output logic [D_BIT-1:0] r_data,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [W:0]       count,
  output logic             ovf,
  output logic             udf
);

  localparam int unsigned DEPTH   = 2**W;
  localparam logic [W:0]  DEPTH_C = (W+1)'(DEPTH);
  localparam logic [W:0]  AF_C    = (W+1)'(AF_LVL);
  localparam logic [W:0]  AE_C    = (W+1)'(AE_LVL);

  logic [D_BIT-1:0] mem_q [DEPTH];
  logic [W-1:0]     w_ptr_q, w_ptr_d;
  logic [W-1:0]     r_ptr_q, r_ptr_d;
  logic [W:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             do_wr, do_rd;

  // Flags decode straight from the occupancy register
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);
  assign count        = count_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;

  // Show-ahead head word, forced to zero when nothing is stored
  always_comb begin
    r_data = '0;
    if (!empty) r_data = mem_q[r_ptr_q];
  end

  // Next-state: clr dominates; a write while full is accepted only alongside a pop
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      do_wr = wr && (!full || rd);
      do_rd = rd && !empty;
      if (do_wr) w_ptr_d = w_ptr_q + W'(1);
      if (do_rd) r_ptr_d = r_ptr_q + W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + (W+1)'(1);
        2'b01:   count_d = count_q - (W+1)'(1);
        default: count_d = count_q;
      endcase
      if (wr && full && !rd) ovf_d = 1'b1;
      if (rd && empty)       udf_d = 1'b1;
    end
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; flush leaves contents in place, reset zeroes them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_wr) begin
      mem_q[w_ptr_q] <= w_data;
    end
  end

endmodule

// File: tb/tb_reg_fifo.sv
// Bench for reg_fifo (defaults D_BIT=8, W=4): queue-based reference model
// checked every falling edge, plus directed scenarios with literal expectations.
module tb_reg_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full, ovf, udf;
  logic [4:0] count;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  reg_fifo dut (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue with occupancy limit DEPTH
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      if (rd && !was_empty) void'(q.pop_front());
      if (wr) begin
        if (!was_full || rd) q.push_back(w_data);
        else m_ovf = 1'b1;
      end
      if (rd && was_empty) m_udf = 1'b1;
    end
  end

  // Compare every falling edge against the model
  always @(negedge clk) begin
    automatic int n = q.size();
    chk("mon_count", 32'(count), 32'(n));
    chk("mon_r_data", 32'(r_data), (n > 0) ? 32'(q[0]) : 32'h0);
    chk("mon_empty", 32'(empty), 32'(n == 0));
    chk("mon_full", 32'(full), 32'(n == DEPTH));
    chk("mon_almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("mon_almost_full", 32'(almost_full), 32'(n >= 14));
    chk("mon_ovf", 32'(ovf), 32'(m_ovf));
    chk("mon_udf", 32'(udf), 32'(m_udf));
  end

  // One clock of requests, starting and ending at a falling edge
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr = w; rd = r; w_data = d;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic flush();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    // 1. reset and idle underflow
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_r_data", 32'(r_data), 32'h0);
    chk("rst_ovf_udf", {30'h0, ovf, udf}, 32'h0);
    step(1'b0, 1'b1, 8'h00);
    chk("idle_rd_udf", 32'(udf), 32'h1);
    chk("idle_rd_count", 32'(count), 32'h0);

    // 2. fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almost_full), 32'(i >= 14));
      chk("fill_ae", 32'(almost_empty), 32'(i <= 2));
      chk("fill_head", 32'(r_data), 32'h01);
    end
    chk("fill_full", 32'(full), 32'h1);

    // 3. overflow then drain
    step(1'b1, 1'b0, 8'hAA);
    chk("ovf_flag", 32'(ovf), 32'h1);
    chk("ovf_count", 32'(count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(r_data), 32'(i));
      step(1'b0, 1'b1, 8'h00);
    end
    chk("drain_empty", 32'(empty), 32'h1);
    chk("drain_r_data", 32'(r_data), 32'h0);
    chk("drain_ovf_sticky", 32'(ovf), 32'h1);

    // 4. wrap-around
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 10; i++) begin
      chk("wrap1_data", 32'(r_data), 32'(8'h30 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    chk("wrap2_count", 32'(count), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk("wrap2_data", 32'(r_data), 32'(8'h20 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    chk("wrap2_count0", 32'(count), 32'h0);

    // 5. simultaneous read/write
    flush();
    chk("clr_ovf", 32'(ovf), 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'(8'h45 + i));
      chk("simul_count", 32'(count), 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      chk("simul_order", 32'(r_data), 32'(8'h44 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b1, 8'h99);
    chk("full_simul_count", 32'(count), 32'd16);
    chk("full_simul_ovf", 32'(ovf), 32'h0);
    chk("full_simul_head", 32'(r_data), 32'h61);
    for (int i = 1; i < 16; i++) begin
      chk("full_simul_drain", 32'(r_data), 32'(8'h60 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    chk("full_simul_last", 32'(r_data), 32'h99);
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h55);
    chk("empty_simul_count", 32'(count), 32'h1);
    chk("empty_simul_data", 32'(r_data), 32'h55);
    chk("empty_simul_udf", 32'(udf), 32'h1);

    // 6. flush and asynchronous reset
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
    chk("pre_clr_count", 32'(count), 32'd7);
    flush();
    chk("clr_count", 32'(count), 32'h0);
    chk("clr_empty", 32'(empty), 32'h1);
    chk("clr_flags", {30'h0, ovf, udf}, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    chk("refill_count", 32'(count), 32'd3);
    chk("refill_head", 32'(r_data), 32'h80);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'h0);
    chk("async_rst_empty", 32'(empty), 32'h1);
    chk("async_rst_r_data", 32'(r_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h5A);
    chk("post_rst_head", 32'(r_data), 32'h5A);
    chk("post_rst_count", 32'(count), 32'h1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_fifo.md
Name: reg_fifo

Overview:
Parametrised synchronous FIFO built on a register-file array. It is the next generation of the UART register file, adding pointer management, occupancy count, threshold flags and sticky error flags. It sits between the UART receiver/transmitter and the host interface and buffers D_BIT-wide words. Read side is show-ahead: the head word is always presented on r_data.

Parameters:
D_BIT, 8, data word width in bits
W, 4, address width; depth = 2**W words
AF_LVL, 2**W-2, almost_full asserts when count >= AF_LVL
AE_LVL, 2, almost_empty asserts when count <= AE_LVL

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
clr  input  1  synchronous flush; empties FIFO and clears error flags
wr  input  1  write request; push w_data
w_data  input  D_BIT  write data
rd  input  1  read request; pop head word
r_data  output  D_BIT  head word (show-ahead); 0 when empty
empty  output  1  count == 0
full  output  1  count == 2**W
almost_empty  output  1  count <= AE_LVL
almost_full  output  1  count >= AF_LVL
count  output  W+1  occupancy, 0..2**W
ovf  output  1  sticky overflow: write attempted while full
udf  output  1  sticky underflow: read attempted while empty

Behaviour:
- Storage: 2**W x D_BIT register array; w_ptr and r_ptr are W bits; count is W+1 bits.
- Reset (async, rst=1): w_ptr=0, r_ptr=0, count=0, all array entries zeroed, ovf=0, udf=0. Outputs during and after reset: r_data=0, empty=1, full=0, almost_empty=1, almost_full=0, count=0. Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- clr=1 at an edge: pointers and count go to 0 and ovf/udf go to 0. Array contents are not zeroed. clr has priority over wr/rd in the same cycle; wr/rd are ignored.
- Write: wr=1 and not full -> mem[w_ptr]<=w_data, w_ptr+1 (wraps 2**W-1 -> 0), count+1.
- Read: rd=1 and not empty -> r_ptr+1 (wraps), count-1. The popped word is the one on r_data before the edge. The next head appears after the edge.
- r_data = mem[r_ptr] combinationally when !empty, 0 when empty. Latency: a word written at edge N is visible on r_data after edge N if the FIFO was empty.
- Simultaneous wr=1, rd=1:
  - Neither full nor empty: both execute, count unchanged.
  - Full: both execute, count stays 2**W, ovf not set.
  - Empty: write executes, read ignored, udf set, count becomes 1.
- Error cases:
  - Write while full (without a simultaneous valid read): data dropped, state unchanged, ovf<=1.
  - Read while empty: state unchanged, udf<=1.
  - ovf/udf hold until rst or clr.
- Flags are combinational from count. When no state-changing request occurs, outputs are stable.
- Threshold parameters must satisfy 0 <= AE_LVL < AF_LVL <= 2**W. Behaviour outside this range is undefined.

Test Plan:
1. Reset then idle: assert rst for 3 cycles, release -> empty=1, count=0, r_data=0, ovf=udf=0. Pulse rd once -> udf=1, count stays 0.
2. Fill (defaults D_BIT=8, W=4): write 0x01..0x10 on 16 consecutive cycles -> count steps 1..16. almost_full=1 from count=14. full=1 after the 16th write. r_data=0x01 throughout.
3. Overflow: with FIFO full, write 0xAA -> ovf=1, count=16, contents unchanged. Drain 16 reads -> r_data sequence 0x01..0x10, then empty=1, r_data=0, ovf remains 1.
4. Wrap-around: write 10, read 10, then write 12 words 0x20..0x2B and read 12 -> data order preserved across the pointer wrap, count returns to 0.
5. Simultaneous: with count=5, wr=rd=1 for 4 cycles -> count stays 5, order preserved. With full, wr=rd=1 -> count=16, ovf=0. With empty, wr=rd=1 (w_data=0x55) -> count=1, r_data=0x55, udf=1.
6. Flush and async reset: with count=7, assert clr -> count=0, empty=1, ovf=udf=0. Refill to 3, then raise rst between clock edges -> count=0 and empty=1 immediately, before the next edge.
